// File: rtl/mult_serial_q.sv
// +----------------------------------------------------------------------+
// | mult_serial_q : bit-serial signed Q1.x multiplier, valid/ready I/O   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mult_serial_q #(
  parameter int NB_DATA = 4,
  parameter int NB_OUT  = 4,
  parameter int ROUND   = 0,
  parameter int SAT     = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NB_DATA-1:0]  i_a,
  input  logic [NB_DATA-1:0]  i_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [NB_OUT-1:0]   o_mult,
  output logic                o_sat
);

  localparam int c_ACC_W = 2 * NB_DATA;
  localparam int c_CNT_W = (NB_DATA > 2) ? $clog2(NB_DATA) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NB_DATA - 1);
  localparam logic [NB_OUT-1:0]  c_MAX  = {1'b0, {(NB_OUT-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [NB_DATA-1:0]   r_a;
  logic [NB_DATA-1:0]   r_b;
  logic [c_ACC_W-1:0]   r_acc;
  logic [c_CNT_W-1:0]   r_cnt;

  logic [c_ACC_W-1:0]   w_a_ext;
  logic [c_ACC_W-1:0]   w_pp;
  logic [c_ACC_W-1:0]   w_acc_next;
  logic [c_ACC_W-1:0]   w_rnd;
  logic                 w_ovf;
  logic [NB_OUT-1:0]    w_mult;
  logic                 w_unused;

  assign w_a_ext = {{NB_DATA{r_a[NB_DATA-1]}}, r_a};
  assign w_pp    = w_a_ext << r_cnt;

  // The multiplier MSB carries negative weight, so its partial product is subtracted.
  always_comb begin
    w_acc_next = r_acc;
    if (r_b[0]) begin
      if (r_cnt == c_LAST) w_acc_next = r_acc - w_pp;
      else                 w_acc_next = r_acc + w_pp;
    end
  end

  generate
    if (ROUND != 0 && NB_OUT < 2 * NB_DATA - 1) begin : g_round
      localparam int c_RND_POS = 2 * NB_DATA - 2 - NB_OUT;
      assign w_rnd = w_acc_next + (c_ACC_W'(1) << c_RND_POS);
    end else begin : g_trunc
      assign w_rnd = w_acc_next;
    end
  endgenerate

  // Only a value >= +1 can overflow, which shows up as the two top bits disagreeing.
  assign w_ovf    = w_rnd[c_ACC_W-1] ^ w_rnd[c_ACC_W-2];
  assign w_mult   = (SAT != 0 && w_ovf) ? c_MAX : w_rnd[c_ACC_W-2 -: NB_OUT];
  assign w_unused = ^w_rnd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_mult  <= '0;
      o_sat   <= 1'b0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid && o_ready) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            o_ready <= 1'b0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_next;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) begin
            o_mult  <= w_mult;
            o_sat   <= w_ovf;
            o_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_serial_q.sv
// +----------------------------------------------------------------------+
// | tb_mult_serial_q : vector table + random reference checks            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mult_serial_q;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic       tb_rst;
  logic       v4, r4, v8, r8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;

  logic        rdy_t, vld_t, s_t, rdy_r, vld_r, s_r, rdy_w, vld_w, s_w;
  logic [3:0]  m_t, m_r, m_w;
  logic        rdy_b1, vld_b1, s_b1, rdy_b2, vld_b2, s_b2;
  logic [11:0] m_b1, m_b2;

  int n_vec = 0;
  int n_err = 0;

  mult_serial_q #(.NB_DATA(4), .NB_OUT(4), .ROUND(0), .SAT(1)) dut_t (
    .i_clk(tb_clk), .i_rst(tb_rst), .i_valid(v4), .o_ready(rdy_t), .i_a(a4), .i_b(b4),
    .o_valid(vld_t), .i_ready(r4), .o_mult(m_t), .o_sat(s_t));
  mult_serial_q #(.NB_DATA(4), .NB_OUT(4), .ROUND(1), .SAT(1)) dut_r (
    .i_clk(tb_clk), .i_rst(tb_rst), .i_valid(v4), .o_ready(rdy_r), .i_a(a4), .i_b(b4),
    .o_valid(vld_r), .i_ready(r4), .o_mult(m_r), .o_sat(s_r));
  mult_serial_q #(.NB_DATA(4), .NB_OUT(4), .ROUND(0), .SAT(0)) dut_w (
    .i_clk(tb_clk), .i_rst(tb_rst), .i_valid(v4), .o_ready(rdy_w), .i_a(a4), .i_b(b4),
    .o_valid(vld_w), .i_ready(r4), .o_mult(m_w), .o_sat(s_w));
  mult_serial_q #(.NB_DATA(8), .NB_OUT(12), .ROUND(1), .SAT(1)) dut_b1 (
    .i_clk(tb_clk), .i_rst(tb_rst), .i_valid(v8), .o_ready(rdy_b1), .i_a(a8), .i_b(b8),
    .o_valid(vld_b1), .i_ready(r8), .o_mult(m_b1), .o_sat(s_b1));
  mult_serial_q #(.NB_DATA(8), .NB_OUT(12), .ROUND(0), .SAT(0)) dut_b2 (
    .i_clk(tb_clk), .i_rst(tb_rst), .i_valid(v8), .o_ready(rdy_b2), .i_a(a8), .i_b(b8),
    .o_valid(vld_b2), .i_ready(r8), .o_mult(m_b2), .o_sat(s_b2));

  // ready and valid must never be high together on any instance
  always @(negedge tb_clk) begin
    if (!tb_rst && ((rdy_t && vld_t) || (rdy_r && vld_r) || (rdy_w && vld_w) ||
                    (rdy_b1 && vld_b1) || (rdy_b2 && vld_b2))) begin
      n_err++;
      $display("FAIL ready_valid_overlap: got both high, required exclusive at %0t", $time);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic longint fdiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && ((n < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  // Reference: exact product scaled to the output grid, then floor/round and saturate/wrap.
  task automatic ref_q(input int nbd, input int nbo, input int rnd, input int sat,
                       input longint a, input longint b,
                       output logic [31:0] q_bits, output logic ovf);
    longint p, d, q, top;
    int sh;
    p = a * b;
    sh = 2 * nbd - 1 - nbo;
    d = 1;
    repeat (sh) d = d * 2;
    top = 1;
    repeat (nbo - 1) top = top * 2;
    if (rnd != 0 && sh > 0) q = fdiv(2 * p + d, 2 * d);
    else                    q = fdiv(p, d);
    ovf = (q >= top);
    if (ovf) q = (sat != 0) ? top - 1 : q - 2 * top;
    q_bits = 32'(q) & 32'(2 * top - 1);
  endtask

  // Accept one operand pair on the 4-bit group and wait (bounded) until a result is valid.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit scramble,
                     input logic rin, output int lat);
    a4 = a; b4 = b; v4 = 1'b1; r4 = rin;
    @(posedge tb_clk); #1;
    v4 = 1'b0;
    lat = 0;
    while (!vld_t && lat < 40) begin
      if (scramble) begin
        a4 = 4'($urandom); b4 = 4'($urandom); v4 = 1'($urandom);
      end
      @(posedge tb_clk); #1;
      lat++;
    end
    v4 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
    a8 = a; b8 = b; v8 = 1'b1; r8 = 1'b1;
    @(posedge tb_clk); #1;
    v8 = 1'b0;
    lat = 0;
    while (!vld_b1 && lat < 60) begin
      @(posedge tb_clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         cfg;    // 0 truncate+sat, 1 round+sat, 2 truncate+wrap
    logic [3:0] exp_m;
    logic       exp_s;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat;
    logic [31:0] q;
    logic ovf;
    logic [3:0] ra, rb;
    logic [7:0] ba, bb;

    vecs[0]  = '{4'h4, 4'h8, 0, 4'hC, 1'b0};
    vecs[1]  = '{4'hC, 4'hC, 0, 4'h2, 1'b0};
    vecs[2]  = '{4'hE, 4'h9, 0, 4'h1, 1'b0};
    vecs[3]  = '{4'h1, 4'hC, 0, 4'hF, 1'b0};
    vecs[4]  = '{4'hC, 4'h9, 0, 4'h3, 1'b0};
    vecs[5]  = '{4'h4, 4'h7, 0, 4'h3, 1'b0};
    vecs[6]  = '{4'hE, 4'h9, 1, 4'h2, 1'b0};
    vecs[7]  = '{4'hC, 4'h9, 1, 4'h4, 1'b0};
    vecs[8]  = '{4'h1, 4'hC, 1, 4'h0, 1'b0};
    vecs[9]  = '{4'h8, 4'h8, 0, 4'h7, 1'b1};
    vecs[10] = '{4'h8, 4'h8, 2, 4'h8, 1'b1};

    tb_rst = 1'b1;
    v4 = 1'b0; r4 = 1'b1; a4 = '0; b4 = '0;
    v8 = 1'b0; r8 = 1'b1; a8 = '0; b8 = '0;

    // Reset held for five cycles
    repeat (5) begin
      @(posedge tb_clk); #1;
    end
    chk("rst_ready", 32'(rdy_t), 32'd1);
    chk("rst_valid", 32'(vld_t), 32'd0);
    chk("rst_mult", 32'(m_t), 32'd0);
    chk("rst_sat", 32'(s_t), 32'd0);
    chk("rst_big_ready", 32'(rdy_b1), 32'd1);
    tb_rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      op4(vecs[i].a, vecs[i].b, 1'b0, 1'b1, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      case (vecs[i].cfg)
        0: begin
          chk($sformatf("vec%0d_mult", i), 32'(m_t), 32'(vecs[i].exp_m));
          chk($sformatf("vec%0d_sat", i), 32'(s_t), 32'(vecs[i].exp_s));
        end
        1: begin
          chk($sformatf("vec%0d_mult", i), 32'(m_r), 32'(vecs[i].exp_m));
          chk($sformatf("vec%0d_sat", i), 32'(s_r), 32'(vecs[i].exp_s));
        end
        default: begin
          chk($sformatf("vec%0d_mult", i), 32'(m_w), 32'(vecs[i].exp_m));
          chk($sformatf("vec%0d_sat", i), 32'(s_w), 32'(vecs[i].exp_s));
        end
      endcase
      @(posedge tb_clk); #1;
      chk($sformatf("vec%0d_ready_after_ack", i), 32'(rdy_t), 32'd1);
    end

    // Backpressure with inputs toggling during BUSY and DONE
    op4(4'hE, 4'h9, 1'b1, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    chk("bp_mult", 32'(m_t), 32'h1);
    for (int c = 0; c < 6; c++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); v4 = 1'($urandom);
      @(posedge tb_clk); #1;
      chk($sformatf("bp_hold_mult_c%0d", c), 32'(m_t), 32'h1);
      chk($sformatf("bp_hold_ready_c%0d", c), 32'(rdy_t), 32'd0);
      chk($sformatf("bp_hold_valid_c%0d", c), 32'(vld_t), 32'd1);
    end
    v4 = 1'b0; r4 = 1'b1;
    @(posedge tb_clk); #1;
    chk("bp_release_ready", 32'(rdy_t), 32'd1);
    chk("bp_release_valid", 32'(vld_t), 32'd0);

    // Reset in the second BUSY cycle aborts the operation
    a4 = 4'h7; b4 = 4'h7; v4 = 1'b1;
    @(posedge tb_clk); #1;
    v4 = 1'b0;
    @(posedge tb_clk); #1;
    tb_rst = 1'b1;
    #1;
    chk("abort_ready", 32'(rdy_t), 32'd1);
    chk("abort_valid", 32'(vld_t), 32'd0);
    chk("abort_mult", 32'(m_t), 32'd0);
    @(posedge tb_clk); #1;
    tb_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge tb_clk); #1;
      chk($sformatf("abort_no_valid_c%0d", c), 32'(vld_t), 32'd0);
    end
    op4(4'h4, 4'h4, 1'b0, 1'b1, lat);
    chk("post_abort_latency", 32'(lat), 32'd4);
    chk("post_abort_mult", 32'(m_t), 32'h2);
    @(posedge tb_clk); #1;

    // Random 4-bit pairs against the reference, all three 4-bit configurations
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      op4(ra, rb, 1'b0, 1'b1, lat);
      chk("r4_latency", 32'(lat), 32'd4);
      ref_q(4, 4, 0, 1, longint'($signed(ra)), longint'($signed(rb)), q, ovf);
      chk($sformatf("r4_trunc_%0h_%0h", ra, rb), 32'(m_t), q);
      chk("r4_trunc_sat", 32'(s_t), 32'(ovf));
      ref_q(4, 4, 1, 1, longint'($signed(ra)), longint'($signed(rb)), q, ovf);
      chk($sformatf("r4_round_%0h_%0h", ra, rb), 32'(m_r), q);
      chk("r4_round_sat", 32'(s_r), 32'(ovf));
      ref_q(4, 4, 0, 0, longint'($signed(ra)), longint'($signed(rb)), q, ovf);
      chk($sformatf("r4_wrap_%0h_%0h", ra, rb), 32'(m_w), q);
      chk("r4_wrap_sat", 32'(s_w), 32'(ovf));
      @(posedge tb_clk); #1;
    end

    // 8-bit operands, 12-bit result; first two pairs are the extreme corners
    for (int i = 0; i < 1000; i++) begin
      if (i == 0)      begin ba = 8'h80; bb = 8'h80; end
      else if (i == 1) begin ba = 8'h80; bb = 8'h7F; end
      else             begin ba = 8'($urandom); bb = 8'($urandom); end
      op8(ba, bb, lat);
      chk("r8_latency", 32'(lat), 32'd8);
      ref_q(8, 12, 1, 1, longint'($signed(ba)), longint'($signed(bb)), q, ovf);
      chk($sformatf("r8_round_sat_%0h_%0h", ba, bb), 32'(m_b1), q);
      chk("r8_round_sat_flag", 32'(s_b1), 32'(ovf));
      ref_q(8, 12, 0, 0, longint'($signed(ba)), longint'($signed(bb)), q, ovf);
      chk($sformatf("r8_trunc_wrap_%0h_%0h", ba, bb), 32'(m_b2), q);
      chk("r8_trunc_wrap_flag", 32'(s_b2), 32'(ovf));
      @(posedge tb_clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_serial_q.md
# mult_serial_q

Parametrised bit-serial signed fractional multiplier with valid/ready handshakes on input and output. It computes a product of two Q1.(NB_DATA-1) operands, one multiplier bit per clock. The result is Q1.(NB_OUT-1) and can be truncated or rounded, and saturated or wrapped. It sits in datapaths that trade throughput for area (filter taps, gain stages) and supports upstream stalls and downstream backpressure.

## Interface
- NB_DATA, 4: operand width; format Q1.(NB_DATA-1), two's complement; legal range 2..32.
- NB_OUT, 4: result width; format Q1.(NB_OUT-1); legal range 2..2*NB_DATA-1.
- ROUND, 0: 0 = truncate (floor); 1 = round half up.
- SAT, 1: 1 = saturate on overflow; 0 = wrap.
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  operand pair valid.
- o_ready  out  1  block can accept operands.
- i_a  in  NB_DATA  multiplicand, signed.
- i_b  in  NB_DATA  multiplier, signed.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_mult  out  NB_OUT  product, signed.
- o_sat  out  1  overflow occurred on this result; qualified by o_valid.

## Operation
- States:
  - IDLE: o_ready=1.
  - BUSY: NB_DATA cycles.
  - DONE: o_valid=1.
- IDLE -> BUSY on an edge where i_valid && o_ready.
  - i_a and i_b are captured at that edge.
  - Input changes after capture are ignored until the next accept.
- BUSY: one multiplier bit per cycle, LSB first, using a 2*NB_DATA-bit signed accumulator.
  - Bit k (k < NB_DATA-1) set: add sign-extended a << k.
  - Bit NB_DATA-1 set: subtract a << (NB_DATA-1), because the sign bit has negative weight.
  - After NB_DATA steps the accumulator holds the exact product P in Q2.(2*NB_DATA-2).
- Output mapping: take P[2*NB_DATA-2 -: NB_OUT] (drop the redundant top sign bit).
  - ROUND=1: add 1 at bit position 2*NB_DATA-2-NB_OUT before the slice. Only when NB_OUT < 2*NB_DATA-1.
  - Overflow: the true value is ≥ +1. This happens only for (-1)·(-1), or when rounding carries into the sign bit.
    - SAT=1: o_mult = 0 followed by all ones (max positive), o_sat=1.
    - SAT=0: o_mult = the wrapped slice, o_sat=1.
  - Otherwise o_sat=0.
- BUSY -> DONE after the last step. o_mult and o_sat are registered and stable for the whole of DONE.
- DONE -> IDLE on an edge where o_valid && i_ready.
- No accept in DONE. i_valid outside IDLE has no effect.

## Timing
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_mult=0, o_sat=0, accumulator=0.
- Reset asserted in any state aborts the operation immediately (asynchronous). No result is produced for it.
- Accept at edge t0.
  - o_ready falls after t0.
  - o_valid rises after edge t0+NB_DATA (latency NB_DATA cycles).
- Output handshake at edge t1: o_valid falls and o_ready rises after t1.
- Throughput: one result per NB_DATA+2 cycles with i_valid and i_ready held high.
- With i_ready=0, DONE is held indefinitely with no change to o_mult or o_sat.
- o_ready and o_valid are never high in the same cycle.

## Test plan
1. Reset: i_rst=1 for 5 cycles, then released.
   - During reset: o_ready=1, o_valid=0, o_mult=0, o_sat=0.
   - First accept after release works normally.
2. Truncate, NB_DATA=NB_OUT=4, ROUND=0, i_ready=1. Each result appears 4 cycles after accept, o_sat=0.
   - 0100×1000 -> 1100
   - 1100×1100 -> 0010
   - 1110×1001 -> 0001
   - 0001×1100 -> 1111
   - 1100×1001 -> 0011
   - 0100×0111 -> 0011
3. Round, ROUND=1:
   - 1110×1001 -> 0010
   - 1100×1001 -> 0100
   - 0001×1100 -> 0000
4. Overflow with 1000×1000:
   - SAT=1 -> o_mult=0111, o_sat=1.
   - SAT=0 -> o_mult=1000, o_sat=1.
5. Backpressure and stall:
   - Hold i_ready=0 for 6 cycles in DONE: o_mult constant, o_ready=0.
   - Toggle i_a, i_b and i_valid during BUSY and DONE: the result is unaffected.
   - Release i_ready: o_ready=1 on the next cycle.
6. Reset mid-BUSY (cycle 2 of 4): o_valid never rises, state returns to IDLE. The next operation 0100×0100 -> 0010.
   - Then NB_DATA=8, NB_OUT=12: 1000 random pairs checked against a floor/round/saturate reference model.
